// File: rtl/mem_bus_master_pkg.sv
// Shared types and default widths for the memory bus initiator.
package mem_bus_master_pkg;

   localparam int MBM_ADDR_WIDTH = 16;
   localparam int MBM_DATA_WIDTH = 16;
   localparam int MBM_LEN_WIDTH  = 8;

   // Bus strobes are active-low, so the asserted code is 0.
   typedef enum logic {
      MEM_WR = 1'b0,
      NO_WR  = 1'b1
   } wr_cond_code_t;

   typedef enum logic {
      MEM_RD = 1'b0,
      NO_RD  = 1'b1
   } rd_cond_code_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      TURN = 2'd3
   } mbm_state_t;

endpackage

// File: rtl/mem_bus_master_if.sv
// Request, write-stream and read-stream handshakes of the bus initiator.
interface mem_bus_master_if
   import mem_bus_master_pkg::*;
#(
   parameter int ADDR_WIDTH = MBM_ADDR_WIDTH,
   parameter int DATA_WIDTH = MBM_DATA_WIDTH,
   parameter int LEN_WIDTH  = MBM_LEN_WIDTH
);

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [LEN_WIDTH-1:0]  req_len;

   logic                  wr_valid;
   logic                  wr_ready;
   logic [DATA_WIDTH-1:0] wr_data;

   logic                  rd_valid;
   logic                  rd_ready;
   logic [DATA_WIDTH-1:0] rd_data;

   logic                  done;

   modport master (
      input  req_valid, req_write, req_addr, req_len,
      input  wr_valid, wr_data,
      input  rd_ready,
      output req_ready, wr_ready, rd_valid, rd_data, done
   );

   modport slave (
      output req_valid, req_write, req_addr, req_len,
      output wr_valid, wr_data,
      output rd_ready,
      input  req_ready, wr_ready, rd_valid, rd_data, done
   );

endinterface

// File: rtl/mem_bus_master_addr_gen.sv
// Burst address/beat counter: loads on accept, advances once per bus beat.
module mem_bus_master_addr_gen
   import mem_bus_master_pkg::*;
#(
   parameter int ADDR_WIDTH = MBM_ADDR_WIDTH,
   parameter int LEN_WIDTH  = MBM_LEN_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset_L,
   input  logic                  load,
   input  logic                  step,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [LEN_WIDTH-1:0]  load_len,
   output logic [ADDR_WIDTH-1:0] cur_addr,
   output logic                  last
);

   logic [LEN_WIDTH-1:0] beats_left;

   // Address wraps naturally at all-ones; the beat count parks at zero on the last beat.
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         cur_addr   <= '0;
         beats_left <= '0;
      end else if (load) begin
         cur_addr   <= load_addr;
         beats_left <= load_len;
      end else if (step) begin
         cur_addr <= cur_addr + 1'b1;
         if (beats_left != '0) begin
            beats_left <= beats_left - 1'b1;
         end
      end
   end

   assign last = (beats_left == '0);

endmodule

// File: rtl/tridrive.sv
// Tristate driver: puts data on the bus while en_L is low, floats it otherwise.
module tridrive #(
   parameter int WIDTH = 16
) (
   input  logic             en_L,
   input  logic [WIDTH-1:0] data,
   inout  wire  [WIDTH-1:0] bus
);

   assign bus = en_L ? {WIDTH{1'bz}} : data;

endmodule

// File: rtl/mem_bus_master.sv
// Burst initiator for the shared 16-bit memory bus (combinational read, posedge write).
module mem_bus_master
   import mem_bus_master_pkg::*;
#(
   parameter int ADDR_WIDTH = MBM_ADDR_WIDTH,
   parameter int DATA_WIDTH = MBM_DATA_WIDTH,
   parameter int LEN_WIDTH  = MBM_LEN_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset_L,
   mem_bus_master_if.master      bus,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   inout  wire  [DATA_WIDTH-1:0] mem_data,
   output wr_cond_code_t         we_L,
   output rd_cond_code_t         re_L
);

   mbm_state_t            state;
   mbm_state_t            next_state;
   logic                  load;
   logic                  sample;
   logic                  beat;
   logic                  last;
   logic [ADDR_WIDTH-1:0] cur_addr;

   mem_bus_master_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .LEN_WIDTH  (LEN_WIDTH)
   ) u_addr_gen (
      .clock     (clock),
      .reset_L   (reset_L),
      .load      (load),
      .step      (sample | beat),
      .load_addr (bus.req_addr),
      .load_len  (bus.req_len),
      .cur_addr  (cur_addr),
      .last      (last)
   );

   // The bus is only driven during an actual write beat, so a reset releases it at once.
   tridrive #(
      .WIDTH (DATA_WIDTH)
   ) u_tridrive (
      .en_L (~beat),
      .data (bus.wr_data),
      .bus  (mem_data)
   );

   assign mem_addr = cur_addr;

   // State register.
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state, handshakes and bus strobes; a pending read beat blocks new requests.
   always_comb begin
      next_state    = state;
      load          = 1'b0;
      sample        = 1'b0;
      beat          = 1'b0;
      bus.req_ready = 1'b0;
      bus.wr_ready  = 1'b0;
      bus.done      = 1'b0;
      we_L          = NO_WR;
      re_L          = NO_RD;
      case (state)
         IDLE: begin
            bus.req_ready = ~bus.rd_valid;
            if (bus.req_valid && !bus.rd_valid) begin
               load       = 1'b1;
               next_state = bus.req_write ? WR : RD;
            end
         end
         RD: begin
            if (!bus.rd_valid || bus.rd_ready) begin
               sample = 1'b1;
               re_L   = MEM_RD;
               if (last) begin
                  next_state = TURN;
               end
            end
         end
         WR: begin
            bus.wr_ready = 1'b1;
            if (bus.wr_valid) begin
               beat = 1'b1;
               we_L = MEM_WR;
               if (last) begin
                  next_state = TURN;
               end
            end
         end
         TURN: begin
            bus.done   = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Read stream register: capture on a sample, otherwise drain when the consumer takes it.
   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         bus.rd_valid <= 1'b0;
         bus.rd_data  <= '0;
      end else if (sample) begin
         bus.rd_valid <= 1'b1;
         bus.rd_data  <= mem_data;
      end else if (bus.rd_ready) begin
         bus.rd_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_bus_master.sv
// Scoreboard bench for mem_bus_master with a behavioural memory on the shared bus.
module tb_mem_bus_master;
   import mem_bus_master_pkg::*;

   logic          clock = 1'b0;
   logic          reset_L;
   logic [15:0]   mem_addr;
   wire  [15:0]   mem_data;
   wr_cond_code_t we_L;
   rd_cond_code_t re_L;

   logic          pre_en;
   logic [15:0]   pre_addr;
   logic [15:0]   pre_data;
   logic [15:0]   mem [0:65535];

   logic [15:0]   rd_exp_q [$];
   logic [31:0]   wr_exp_q [$];

   int vectors_applied = 0;
   int miscompares     = 0;
   int cyc             = 0;
   int re_count        = 0;
   int we_count        = 0;
   int rd_pops         = 0;
   int last_we_cycle   = 0;
   int gap             = -1;
   int gap_events      = 0;
   bit last_strobe_we  = 1'b0;

   always #5 clock = ~clock;

   mem_bus_master_if bus_if ();

   mem_bus_master dut (
      .clock    (clock),
      .reset_L  (reset_L),
      .bus      (bus_if),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .we_L     (we_L),
      .re_L     (re_L)
   );

   // Memory responder: combinational read, write latched at the rising edge.
   assign mem_data = (re_L == MEM_RD) ? mem[mem_addr] : 16'bz;

   always @(posedge clock) begin
      if (we_L == MEM_WR) mem[mem_addr] <= mem_data;
      else if (pre_en)    mem[pre_addr] <= pre_data;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vectors_applied++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Per-cycle bus observation: strobe exclusivity, write and read scoreboards.
   task automatic monitorCycle();
      logic [31:0] exp_w;
      cyc++;
      if (we_L == MEM_WR && re_L == MEM_RD) checkOutput("strobe_overlap", 1, 0);
      if (re_L == MEM_RD) begin
         re_count++;
         checkOutput("re_only_on_sample", {31'b0, (!bus_if.rd_valid || bus_if.rd_ready)}, 1);
         if (last_strobe_we) begin
            gap = cyc - last_we_cycle - 1;
            gap_events++;
         end
         last_strobe_we = 1'b0;
      end
      if (we_L == MEM_WR) begin
         we_count++;
         last_we_cycle  = cyc;
         last_strobe_we = 1'b1;
         if (wr_exp_q.size() == 0) begin
            checkOutput("wr_unexpected", 1, 0);
         end else begin
            exp_w = wr_exp_q.pop_front();
            checkOutput("wr_addr", {16'b0, mem_addr}, {16'b0, exp_w[31:16]});
            checkOutput("wr_data", {16'b0, mem_data}, {16'b0, exp_w[15:0]});
         end
      end
      if (bus_if.rd_valid && bus_if.rd_ready) begin
         rd_pops++;
         if (rd_exp_q.size() == 0) checkOutput("rd_unexpected", 1, 0);
         else checkOutput("rd_data", {16'b0, bus_if.rd_data}, {16'b0, rd_exp_q.pop_front()});
      end
   endtask

   task automatic stepCycle();
      @(negedge clock);
      monitorCycle();
      @(posedge clock);
      #1;
   endtask

   task automatic preloadWord(input logic [15:0] addr, input logic [15:0] data);
      pre_en   = 1'b1;
      pre_addr = addr;
      pre_data = data;
      @(posedge clock);
      #1 pre_en = 1'b0;
   endtask

   task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [7:0] len);
      logic ready_now;
      bit   ok;
      ok = 1'b0;
      bus_if.req_valid = 1'b1;
      bus_if.req_write = wr;
      bus_if.req_addr  = addr;
      bus_if.req_len   = len;
      for (int i = 0; i < 50; i++) begin
         ready_now = bus_if.req_ready;
         stepCycle();
         if (ready_now) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) checkOutput("req_timeout", 0, 1);
      bus_if.req_valid = 1'b0;
   endtask

   task automatic waitDone(input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (bus_if.done) begin
            ok = 1'b1;
            break;
         end
         stepCycle();
      end
      if (!ok) checkOutput(tag, 0, 1);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_req_ready"}, {31'b0, bus_if.req_ready}, 1);
      checkOutput({tag, "_wr_ready"},  {31'b0, bus_if.wr_ready},  0);
      checkOutput({tag, "_rd_valid"},  {31'b0, bus_if.rd_valid},  0);
      checkOutput({tag, "_rd_data"},   {16'b0, bus_if.rd_data},   0);
      checkOutput({tag, "_done"},      {31'b0, bus_if.done},      0);
      checkOutput({tag, "_mem_addr"},  {16'b0, mem_addr},         0);
      checkOutput({tag, "_we_L"},      {31'b0, we_L},             {31'b0, NO_WR});
      checkOutput({tag, "_re_L"},      {31'b0, re_L},             {31'b0, NO_RD});
   endtask

   initial begin
      logic [15:0] wd [3];
      logic [3:0]  pat;
      int          pops0;
      int          re0;
      int          g0;

      reset_L          = 1'b0;
      pre_en           = 1'b0;
      pre_addr         = '0;
      pre_data         = '0;
      bus_if.req_valid = 1'b0;
      bus_if.req_write = 1'b0;
      bus_if.req_addr  = '0;
      bus_if.req_len   = '0;
      bus_if.wr_valid  = 1'b0;
      bus_if.wr_data   = '0;
      bus_if.rd_ready  = 1'b1;

      repeat (2) @(posedge clock);
      #1 checkResetValues("reset");
      reset_L = 1'b1;

      for (int i = 0; i < 5; i++) preloadWord(16'h0020 + 16'(i), 16'(i + 1));

      // Single write beat.
      $display("[TB] single write");
      we_count = 0;
      applyStimulus(1'b1, 16'h0010, 8'd0);
      bus_if.wr_valid = 1'b1;
      bus_if.wr_data  = 16'hBEEF;
      wr_exp_q.push_back({16'h0010, 16'hBEEF});
      stepCycle();
      bus_if.wr_valid = 1'b0;
      checkOutput("sw_done", {31'b0, bus_if.done}, 1);
      checkOutput("sw_req_ready_turn", {31'b0, bus_if.req_ready}, 0);
      stepCycle();
      checkOutput("sw_done_clear", {31'b0, bus_if.done}, 0);
      checkOutput("sw_req_ready_idle", {31'b0, bus_if.req_ready}, 1);
      checkOutput("sw_we_count", we_count, 1);
      checkOutput("sw_mem", {16'b0, mem[16'h0010]}, 32'hBEEF);

      // Four-beat read with the consumer always ready.
      $display("[TB] read burst");
      for (int i = 0; i < 4; i++) rd_exp_q.push_back(16'(i + 1));
      pops0 = rd_pops;
      applyStimulus(1'b0, 16'h0020, 8'd3);
      checkOutput("rd_lat_first", {31'b0, bus_if.rd_valid}, 0);
      stepCycle();
      checkOutput("rd_lat_second", {31'b0, bus_if.rd_valid}, 1);
      waitDone("rd_done_timeout");
      stepCycle();
      checkOutput("rd_burst_rate", rd_pops - pops0, 4);
      checkOutput("rd_drain", rd_exp_q.size(), 0);

      // Same read with a 1,0,0,1 consumer pattern.
      $display("[TB] read backpressure");
      pat = 4'b1001;
      for (int i = 0; i < 4; i++) rd_exp_q.push_back(16'(i + 1));
      re0 = re_count;
      applyStimulus(1'b0, 16'h0020, 8'd3);
      for (int i = 0; i < 80; i++) begin
         if (rd_exp_q.size() == 0) break;
         bus_if.rd_ready = pat[i % 4];
         stepCycle();
      end
      bus_if.rd_ready = 1'b1;
      checkOutput("bp_drain", rd_exp_q.size(), 0);
      checkOutput("bp_re_count", re_count - re0, 4);
      repeat (3) stepCycle();

      // Gapped write burst across the top of the address space.
      $display("[TB] write wrap");
      wd[0] = 16'h1111;
      wd[1] = 16'h2222;
      wd[2] = 16'h3333;
      applyStimulus(1'b1, 16'hFFFE, 8'd2);
      for (int i = 0; i < 5; i++) begin
         if (i % 2 == 0) begin
            bus_if.wr_valid = 1'b1;
            bus_if.wr_data  = wd[i / 2];
            wr_exp_q.push_back({16'hFFFE + 16'(i / 2), wd[i / 2]});
         end else begin
            bus_if.wr_valid = 1'b0;
            #1 checkOutput("ww_gap_we", {31'b0, we_L}, {31'b0, NO_WR});
         end
         stepCycle();
      end
      bus_if.wr_valid = 1'b0;
      checkOutput("ww_done", {31'b0, bus_if.done}, 1);
      checkOutput("ww_mem_fffe", {16'b0, mem[16'hFFFE]}, 32'h1111);
      checkOutput("ww_mem_ffff", {16'b0, mem[16'hFFFF]}, 32'h2222);
      checkOutput("ww_mem_0000", {16'b0, mem[16'h0000]}, 32'h3333);
      checkOutput("ww_wr_drain", wr_exp_q.size(), 0);
      stepCycle();

      // Reset after two of five read beats, then a clean read.
      $display("[TB] reset mid-read");
      for (int i = 0; i < 5; i++) rd_exp_q.push_back(16'(i + 1));
      pops0 = rd_pops;
      applyStimulus(1'b0, 16'h0020, 8'd4);
      for (int i = 0; i < 20; i++) begin
         if (rd_pops - pops0 >= 2) break;
         stepCycle();
      end
      checkOutput("rst_two_beats", rd_pops - pops0, 2);
      reset_L = 1'b0;
      rd_exp_q.delete();
      #1 checkResetValues("midrst");
      @(posedge clock);
      #1 reset_L = 1'b1;
      rd_exp_q.push_back(16'd3);
      rd_exp_q.push_back(16'd4);
      applyStimulus(1'b0, 16'h0022, 8'd1);
      waitDone("rst_read_timeout");
      stepCycle();
      checkOutput("rst_read_drain", rd_exp_q.size(), 0);

      // Write burst immediately followed by a read of the same words.
      $display("[TB] write then read turnaround");
      g0 = gap_events;
      applyStimulus(1'b1, 16'h0030, 8'd1);
      bus_if.wr_valid = 1'b1;
      bus_if.wr_data  = 16'hA5A5;
      wr_exp_q.push_back({16'h0030, 16'hA5A5});
      stepCycle();
      bus_if.wr_data  = 16'h5A5A;
      wr_exp_q.push_back({16'h0031, 16'h5A5A});
      stepCycle();
      bus_if.wr_valid = 1'b0;
      rd_exp_q.push_back(16'hA5A5);
      rd_exp_q.push_back(16'h5A5A);
      applyStimulus(1'b0, 16'h0030, 8'd1);
      waitDone("turn_read_timeout");
      stepCycle();
      checkOutput("turn_gap_events", gap_events - g0, 1);
      checkOutput("turn_gap_cycles", gap, 2);
      checkOutput("turn_read_drain", rd_exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
